// File: rtl/rst_req_pkg.sv
// Shared types for the reset-request initiator: FSM states, cause codes and a
// small constant helper used for counter sizing.
package rst_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_SW   = 2'b01,
    CAUSE_WDT  = 2'b10,
    CAUSE_LOCK = 2'b11
  } cause_t;

  function automatic int unsigned max_int(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/wdt_cnt.sv
// Watchdog down-counter: reloads on disable, kick or hold, flags a timeout at
// zero. A kick in the zero cycle suppresses the timeout.
module wdt_cnt #(
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  input  logic hold,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  assign timeout = en & ~kick & (cnt_r == CW'(0));

  // Reload whenever idle counting must restart, otherwise count down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= RELOAD;
    end else if (!en || kick || hold || (cnt_r == CW'(0))) begin
      cnt_r <= RELOAD;
    end else begin
      cnt_r <= cnt_r - CW'(1);
    end
  end

endmodule

// File: rtl/rst_req_ctl.sv
// Reset-request initiator: stretched active-low request with sticky cause.
// Watchdog source is built only when RST_REQ_WDT_EN is defined.
module rst_req_ctl
  import rst_req_pkg::*;
#(
  parameter int unsigned WDT_TIMEOUT    = 100_000_000,
  parameter int unsigned ASSERT_CYCLES  = 16,
  parameter int unsigned HOLDOFF_CYCLES = 256,
  parameter int unsigned LOCK_FILTER    = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sw_rst_req_i,
  input  logic       wdt_en_i,
  input  logic       wdt_kick_i,
  input  logic       pll_locked_i,
  output logic       rst_req_n_o,
  output logic [1:0] rst_cause_o,
  output logic       busy_o
);

  localparam int unsigned PHASE_W = $clog2(max_int(ASSERT_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam int unsigned LOCK_W  = $clog2(LOCK_FILTER + 1);
  localparam logic [PHASE_W-1:0] ASSERT_LOAD = PHASE_W'(ASSERT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LOAD   = PHASE_W'(HOLDOFF_CYCLES - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST   = LOCK_W'(LOCK_FILTER - 1);
  localparam logic [LOCK_W-1:0]  LOCK_MAX    = LOCK_W'(LOCK_FILTER);

  state_t              state_r;
  cause_t              cause_r;
  logic [PHASE_W-1:0]  phase_r;
  logic [LOCK_W-1:0]   lock_cnt_r;
  logic                armed_r;
  logic                rst_req_n_r;
  logic                busy_r;

  logic   wdt_evt;
  logic   lock_evt;
  logic   fire;
  cause_t win_cause;

`ifdef RST_REQ_WDT_EN
  logic wdt_hold;

  // Counter stays at its reload value from the firing edge until back in IDLE.
  assign wdt_hold = (state_r != IDLE) | fire;

  wdt_cnt #(
    .TIMEOUT (WDT_TIMEOUT)
  ) u_wdt_cnt (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .en      (wdt_en_i),
    .kick    (wdt_kick_i),
    .hold    (wdt_hold),
    .timeout (wdt_evt)
  );
`else
  logic [33:0] unused_wdt;

  assign wdt_evt    = 1'b0;
  assign unused_wdt = {wdt_en_i, wdt_kick_i, 32'(WDT_TIMEOUT)};
`endif

  // Event qualification and fixed-priority cause selection.
  always_comb begin
    lock_evt = armed_r & ~pll_locked_i & (lock_cnt_r >= LOCK_LAST);
    if (state_r == IDLE) begin
      fire = lock_evt | wdt_evt | sw_rst_req_i;
    end else begin
      fire = 1'b0;
    end
    if (lock_evt) begin
      win_cause = CAUSE_LOCK;
    end else if (wdt_evt) begin
      win_cause = CAUSE_WDT;
    end else if (sw_rst_req_i) begin
      win_cause = CAUSE_SW;
    end else begin
      win_cause = CAUSE_NONE;
    end
  end

  // Lock-loss filter: arms on first lock, counts consecutive low cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      armed_r    <= 1'b0;
      lock_cnt_r <= LOCK_W'(0);
    end else begin
      if (pll_locked_i) begin
        armed_r <= 1'b1;
      end
      if (fire || pll_locked_i || !armed_r) begin
        lock_cnt_r <= LOCK_W'(0);
      end else if (lock_cnt_r != LOCK_MAX) begin
        lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
      end
    end
  end

  // Request FSM with registered outputs and a shared phase counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r     <= IDLE;
      phase_r     <= PHASE_W'(0);
      cause_r     <= CAUSE_NONE;
      rst_req_n_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fire) begin
            state_r     <= ASSERT;
            phase_r     <= ASSERT_LOAD;
            cause_r     <= win_cause;
            rst_req_n_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ASSERT: begin
          if (phase_r == PHASE_W'(0)) begin
            state_r     <= HOLDOFF;
            phase_r     <= HOLD_LOAD;
            rst_req_n_r <= 1'b1;
          end else begin
            phase_r <= phase_r - PHASE_W'(1);
          end
        end
        HOLDOFF: begin
          if (phase_r == PHASE_W'(0)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            phase_r <= phase_r - PHASE_W'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          phase_r     <= PHASE_W'(0);
          rst_req_n_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign rst_req_n_o = rst_req_n_r;
  assign rst_cause_o = cause_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_rst_req_ctl.sv
// Self-checking bench for rst_req_ctl: vector table plus hand-written corner
// sequences; watchdog expiry checks apply when RST_REQ_WDT_EN is defined.
module tb_rst_req_ctl;

  localparam int unsigned WDT_T   = 50;
  localparam int unsigned ASSERT_C = 16;
  localparam int unsigned HOLD_C  = 256;
  localparam int unsigned LOCK_F  = 4;
  localparam int          NV      = 17;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw;
  logic       wdt_en;
  logic       kick;
  logic       locked;
  logic       req_n;
  logic [1:0] cause;
  logic       busy;

  rst_req_ctl #(
    .WDT_TIMEOUT    (WDT_T),
    .ASSERT_CYCLES  (ASSERT_C),
    .HOLDOFF_CYCLES (HOLD_C),
    .LOCK_FILTER    (LOCK_F)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .sw_rst_req_i (sw),
    .wdt_en_i     (wdt_en),
    .wdt_kick_i   (kick),
    .pll_locked_i (locked),
    .rst_req_n_o  (req_n),
    .rst_cause_o  (cause),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req_n;
    logic [1:0] cause;
    logic       busy;
  } exp_t;

  typedef struct packed {
    logic        sw;
    logic        en;
    logic        kick;
    logic        locked;
    logic [15:0] cycles;
    exp_t        exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk_exp(input logic r, input logic [1:0] c, input logic b);
    exp_t e;
    e.req_n = r;
    e.cause = c;
    e.busy  = b;
    return e;
  endfunction

  function automatic vec_t mk(input logic s, input logic e, input logic k, input logic l,
                              input int c, input logic r, input logic [1:0] ca, input logic b);
    vec_t v;
    v.sw     = s;
    v.en     = e;
    v.kick   = k;
    v.locked = l;
    v.cycles = 16'(c);
    v.exp    = mk_exp(r, ca, b);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp(input string tag, input string field, input logic [1:0] got, input logic [1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %0b expected %0b", tag, field, got, want);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    cmp(tag, "rst_req_n", {1'b0, req_n}, {1'b0, e.req_n});
    cmp(tag, "rst_cause", cause, e.cause);
    cmp(tag, "busy", {1'b0, busy}, {1'b0, e.busy});
  endtask

  task automatic expect_after(input int n, input logic r, input logic [1:0] c, input logic b, input string tag);
    sb_q.push_back(mk_exp(r, c, b));
    tick(n);
    check_out(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    sw     = 1'b0;
    wdt_en = 1'b0;
    kick   = 1'b0;
    locked = 1'b0;

    // Table: never-armed lock low, glitch, sw path with dropped pulse, lock loss, sw again.
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 20,  1'b1, 2'b00, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5,   1'b1, 2'b00, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 3,   1'b1, 2'b00, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5,   1'b1, 2'b00, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1,   1'b0, 2'b01, 1'b1);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 15,  1'b0, 2'b01, 1'b1);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1,   1'b1, 2'b01, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 100, 1'b1, 2'b01, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 155, 1'b1, 2'b01, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1,   1'b1, 2'b01, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 10,  1'b1, 2'b01, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4,   1'b0, 2'b11, 1'b1);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 16,  1'b1, 2'b11, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 255, 1'b1, 2'b11, 1'b1);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1,   1'b1, 2'b11, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1,   1'b0, 2'b01, 1'b1);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 272, 1'b1, 2'b01, 1'b0);

    expect_after(3, 1'b1, 2'b00, 1'b0, "reset");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      sw     = vecs[i].sw;
      wdt_en = vecs[i].en;
      kick   = vecs[i].kick;
      locked = vecs[i].locked;
      sb_q.push_back(vecs[i].exp);
      tick(1);
      sw   = 1'b0;
      kick = 1'b0;
      tick(int'(vecs[i].cycles) - 1);
      check_out($sformatf("vec%0d", i));
    end

    // Software pulse, watchdog zero and 4th lock-low cycle on one edge.
    wdt_en = 1'b1;
    tick(46);
    locked = 1'b0;
    tick(3);
    sw = 1'b1;
    expect_after(1, 1'b0, 2'b11, 1'b1, "simul_fire");
    sw     = 1'b0;
    locked = 1'b1;
    wdt_en = 1'b0;
    expect_after(15, 1'b0, 2'b11, 1'b1, "simul_width_end");
    expect_after(1, 1'b1, 2'b11, 1'b1, "simul_single_pulse");
    expect_after(256, 1'b1, 2'b11, 1'b0, "simul_idle");

`ifdef RST_REQ_WDT_EN
    wdt_en = 1'b1;
    expect_after(49, 1'b1, 2'b11, 1'b0, "wdt_pre");
    expect_after(1, 1'b0, 2'b10, 1'b1, "wdt_fire");
    wdt_en = 1'b0;
    expect_after(272, 1'b1, 2'b10, 1'b0, "wdt_idle");

    wdt_en = 1'b1;
    tick(49);
    kick = 1'b1;
    expect_after(1, 1'b1, 2'b10, 1'b0, "wdt_kick_wins");
    kick = 1'b0;
    expect_after(49, 1'b1, 2'b10, 1'b0, "wdt_reload_pre");
    expect_after(1, 1'b0, 2'b10, 1'b1, "wdt_reload_fire");
    wdt_en = 1'b0;
    expect_after(272, 1'b1, 2'b10, 1'b0, "wdt_idle2");
`else
    wdt_en = 1'b1;
    expect_after(300, 1'b1, 2'b11, 1'b0, "wdt_absent");
    wdt_en = 1'b0;
`endif

    // Kicks every 40 cycles keep the watchdog quiet for 1000 cycles.
    wdt_en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick(39);
      kick = 1'b1;
`ifdef RST_REQ_WDT_EN
      expect_after(1, 1'b1, 2'b10, 1'b0, $sformatf("wdt_kicked%0d", k));
`else
      expect_after(1, 1'b1, 2'b11, 1'b0, $sformatf("wdt_kicked%0d", k));
`endif
      kick = 1'b0;
    end
    wdt_en = 1'b0;

    // Power-on reset in the 5th ASSERT cycle aborts the request and clears the cause.
    sw = 1'b1;
    expect_after(1, 1'b0, 2'b01, 1'b1, "abort_assert");
    sw = 1'b0;
    tick(4);
    rst_n = 1'b0;
    expect_after(1, 1'b1, 2'b00, 1'b0, "abort_reset");
    rst_n = 1'b1;
    expect_after(20, 1'b1, 2'b00, 1'b0, "abort_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
